// File: rtl/io_pad_mux.sv
// io_pad_mux: Wishbone-configured pad multiplexer (GPIO + peripheral functions) with input synchronisers.
// Define IO_PAD_MUX_IRQ_EN to build the edge detector and IRQ_PEND logic; otherwise irq is tied low.
module io_pad_mux #(
  parameter int          NUM_PADS  = 38,
  parameter int          NUM_FUNCS = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              wbs_stb_i,
  input  logic                              wbs_cyc_i,
  input  logic                              wbs_we_i,
  input  logic [3:0]                        wbs_sel_i,
  input  logic [31:0]                       wbs_adr_i,
  input  logic [31:0]                       wbs_dat_i,
  output logic                              wbs_ack_o,
  output logic [31:0]                       wbs_dat_o,
  input  logic [(NUM_FUNCS-1)*NUM_PADS-1:0] periph_out,
  input  logic [(NUM_FUNCS-1)*NUM_PADS-1:0] periph_oe,
  output logic [NUM_PADS-1:0]               pad_in_sync,
  input  logic [NUM_PADS-1:0]               io_in,
  output logic [NUM_PADS-1:0]               io_out,
  output logic [NUM_PADS-1:0]               io_oeb,
  output logic [2:0]                        irq
);

  localparam logic [9:0] OFF_OUT_LO  = 10'h040;
  localparam logic [9:0] OFF_OUT_HI  = 10'h041;
  localparam logic [9:0] OFF_IN_LO   = 10'h042;
  localparam logic [9:0] OFF_IN_HI   = 10'h043;
  localparam logic [9:0] OFF_PEND_LO = 10'h044;
  localparam logic [9:0] OFF_PEND_HI = 10'h045;

  logic                         ack_q;
  logic [31:0]                  dat_q, rdata;
  logic                         hit, acc, wr_en;
  logic [9:0]                   offset;
  logic [NUM_PADS-1:0][1:0]     fsel_q, fsel_d;
  logic [NUM_PADS-1:0]          oe_q, oe_d, lock_q, lock_d, gpio_out_q, gpio_out_d;
  logic [NUM_PADS-1:0]          meta_q, sync_q;
  logic [NUM_PADS-1:0]          rise_rd, fall_rd, pend_rd;
  logic [63:0]                  out_ext, in_ext, pend_ext;
  logic                         unused_adr;

  assign offset     = wbs_adr_i[11:2];
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  // Accepting only while ack is low gives the mandatory idle cycle between acks.
  assign acc        = hit & ~ack_q;
  assign wr_en      = acc & wbs_we_i;
  assign unused_adr = ^wbs_adr_i[1:0];

  assign out_ext  = 64'(gpio_out_q);
  assign in_ext   = 64'(sync_q);
  assign pend_ext = 64'(pend_rd);

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign pad_in_sync = sync_q;

  always_comb begin : cfg_next
    fsel_d     = fsel_q;
    oe_d       = oe_q;
    lock_d     = lock_q;
    gpio_out_d = gpio_out_q;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (wr_en && wbs_sel_i[0] && offset == 10'(p) && !lock_q[p]) begin
        fsel_d[p] = wbs_dat_i[1:0];
        oe_d[p]   = wbs_dat_i[2];
        lock_d[p] = wbs_dat_i[3];
      end
      if (wr_en && offset == OFF_OUT_LO + 10'(p / 32) && wbs_sel_i[(p % 32) / 8])
        gpio_out_d[p] = wbs_dat_i[p % 32];
    end
  end

  always_comb begin : read_mux
    rdata = '0;
    for (int p = 0; p < NUM_PADS; p++)
      if (offset == 10'(p))
        rdata[5:0] = {fall_rd[p], rise_rd[p], lock_q[p], oe_q[p], fsel_q[p]};
    case (offset)
      OFF_OUT_LO:  rdata = out_ext[31:0];
      OFF_OUT_HI:  rdata = out_ext[63:32];
      OFF_IN_LO:   rdata = in_ext[31:0];
      OFF_IN_HI:   rdata = in_ext[63:32];
      OFF_PEND_LO: rdata = pend_ext[31:0];
      OFF_PEND_HI: rdata = pend_ext[63:32];
      default:     ;
    endcase
  end

  // FSEL values with no matching function never match below, so they fall back to GPIO.
  always_comb begin : pad_mux
    for (int p = 0; p < NUM_PADS; p++) begin
      io_out[p] = gpio_out_q[p];
      io_oeb[p] = ~oe_q[p];
      for (int f = 1; f < NUM_FUNCS; f++) begin
        if (fsel_q[p] == 2'(f)) begin
          io_out[p] = periph_out[(f-1)*NUM_PADS + p];
          io_oeb[p] = ~periph_oe[(f-1)*NUM_PADS + p];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      fsel_q     <= '0;
      oe_q       <= '0;
      lock_q     <= '0;
      gpio_out_q <= '0;
      meta_q     <= '0;
      sync_q     <= '0;
    end else begin
      ack_q      <= acc;
      dat_q      <= (acc && !wbs_we_i) ? rdata : '0;
      fsel_q     <= fsel_d;
      oe_q       <= oe_d;
      lock_q     <= lock_d;
      gpio_out_q <= gpio_out_d;
      meta_q     <= io_in;
      sync_q     <= meta_q;
    end
  end

`ifdef IO_PAD_MUX_IRQ_EN
  logic [NUM_PADS-1:0] rise_q, rise_d, fall_q, fall_d, prev_q, pend_q, pend_d, clr;
  logic                irq_q;

  always_comb begin : irq_next
    rise_d = rise_q;
    fall_d = fall_q;
    clr    = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (wr_en && wbs_sel_i[0] && offset == 10'(p) && !lock_q[p]) begin
        rise_d[p] = wbs_dat_i[4];
        fall_d[p] = wbs_dat_i[5];
      end
      if (wr_en && offset == OFF_PEND_LO + 10'(p / 32) && wbs_sel_i[(p % 32) / 8])
        clr[p] = wbs_dat_i[p % 32];
    end
    // A new edge in the same cycle as its W1C clear wins.
    pend_d = (pend_q & ~clr) | (rise_q & sync_q & ~prev_q) | (fall_q & ~sync_q & prev_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      prev_q <= sync_q;
      pend_q <= pend_d;
      irq_q  <= |pend_q;
    end
  end

  assign rise_rd = rise_q;
  assign fall_rd = fall_q;
  assign pend_rd = pend_q;
  assign irq     = {2'b00, irq_q};
`else
  assign rise_rd = '0;
  assign fall_rd = '0;
  assign pend_rd = '0;
  assign irq     = 3'b000;
`endif

endmodule

// File: tb/tb_io_pad_mux.sv
// Self-checking bench for io_pad_mux (NUM_PADS=38, NUM_FUNCS=3); bus reads checked via an expected-data queue.
module tb_io_pad_mux;
  localparam int          NP   = 38;
  localparam int          NF   = 3;
  localparam int          PW   = (NF-1)*NP;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = '0, wdat = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [PW-1:0] p_out = '0, p_oe = '0;
  logic [NP-1:0] sync_o;
  logic [NP-1:0] io_in = '0;
  logic [NP-1:0] io_out, io_oeb;
  logic [2:0]    irq;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;
  rd_exp_t sb[$];

  io_pad_mux #(.NUM_PADS(NP), .NUM_FUNCS(NF), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .periph_out(p_out), .periph_oe(p_oe),
    .pad_in_sync(sync_o), .io_in(io_in),
    .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One bus transaction; ack must appear exactly one edge after the request.
  task automatic wb_cycle(input logic w, input logic [11:0] off, input logic [31:0] d, input logic [3:0] s);
    rd_exp_t e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); wdat = d; sel = s;
    @(posedge clk); #1;
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_latency off=%h got=%b want=1", off, ack);
    end
    if (!w) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow off=%h got=%h want=<queued entry>", off, rdat);
      end else begin
        e = sb.pop_front();
        if (rdat !== e.exp) begin
          miscompares++;
          $display("FAIL %s got=%h want=%h", e.name, rdat, e.exp);
        end
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s);
    wb_cycle(1'b1, off, d, s);
  endtask

  task automatic wb_read(input logic [11:0] off, input logic [31:0] exp, input string name);
    sb.push_back('{exp: exp, name: name});
    wb_cycle(1'b0, off, 32'h0, 4'hF);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++;
    if (io_oeb !== '1 || io_out !== '0) begin
      miscompares++;
      $display("FAIL reset_pads got oeb=%h out=%h want oeb=all1 out=0", io_oeb, io_out);
    end
    vectors++;
    if (ack !== 1'b0 || rdat !== 32'h0 || irq !== 3'b000 || sync_o !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got ack=%b dat=%h irq=%b sync=%h want 0", ack, rdat, irq, sync_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int p = 0; p < NP; p++) wb_read(12'(p*4), 32'h0, $sformatf("reset_padcfg%0d", p));
  endtask

  task automatic test_gpio();
    wb_write(12'h014, 32'h4, 4'hF);
    wb_write(12'h100, 32'h20, 4'hF);
    vectors++;
    if (io_oeb[5] !== 1'b0 || io_out[5] !== 1'b1 || io_out[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL gpio_pad5 got oeb=%b out=%b out4=%b want 0,1,0", io_oeb[5], io_out[5], io_out[4]);
    end
    wb_read(12'h014, 32'h4, "padcfg5");
    wb_write(12'h100, 32'hFFFF_FFFF, 4'b0010);
    wb_read(12'h100, 32'h0000_FF20, "gpio_out_lo_bytemask");
    wb_write(12'h104, 32'hFFFF_FFFF, 4'hF);
    wb_read(12'h104, 32'h0000_003F, "gpio_out_hi");
    vectors++;
    if (io_out[37] !== 1'b1 || io_oeb[37] !== 1'b1) begin
      miscompares++;
      $display("FAIL gpio_pad37 got out=%b oeb=%b want 1,1", io_out[37], io_oeb[37]);
    end
  endtask

  task automatic test_gpio_in();
    logic [NP-1:0] pat;
    pat = NP'({$urandom, $urandom});
    pat[33] = 1'b0;
    @(negedge clk) io_in = pat;
    @(posedge clk); #1;
    vectors++;
    if (sync_o !== '0) begin
      miscompares++;
      $display("FAIL sync_stage1 got=%h want=0", sync_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (sync_o !== pat) begin
      miscompares++;
      $display("FAIL sync_stage2 got=%h want=%h", sync_o, pat);
    end
    wb_read(12'h108, pat[31:0], "gpio_in_lo");
    wb_read(12'h10C, {26'h0, pat[37:32]}, "gpio_in_hi");
  endtask

  task automatic test_periph();
    wb_write(12'h078, 32'h2, 4'hF);
    p_oe = '0; p_out = '0;
    p_oe[NP+30] = 1'b1;
    p_out[30]   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) p_out[NP+30] = i[0];
      #1;
      vectors++;
      if (io_out[30] !== i[0] || io_oeb[30] !== 1'b0) begin
        miscompares++;
        $display("FAIL periph_f2_toggle%0d got out=%b oeb=%b want %b,0", i, io_out[30], io_oeb[30], i[0]);
      end
    end
    p_oe[NP+30] = 1'b0; #1;
    vectors++;
    if (io_oeb[30] !== 1'b1) begin
      miscompares++;
      $display("FAIL periph_f2_oe got oeb=%b want 1", io_oeb[30]);
    end
    wb_write(12'h078, 32'h1, 4'hF);
    vectors++;
    if (io_out[30] !== 1'b1 || io_oeb[30] !== 1'b1) begin
      miscompares++;
      $display("FAIL periph_f1 got out=%b oeb=%b want 1,1", io_out[30], io_oeb[30]);
    end
    p_out = '1; p_oe = '1;
    wb_write(12'h078, 32'h3, 4'hF);
    vectors++;
    if (io_out[30] !== 1'b0 || io_oeb[30] !== 1'b1) begin
      miscompares++;
      $display("FAIL fsel_clamp got out=%b oeb=%b want 0,1", io_out[30], io_oeb[30]);
    end
    wb_read(12'h078, 32'h3, "padcfg30_stored");
    p_out = '0; p_oe = '0;
  endtask

  task automatic test_lock();
    wb_write(12'h01C, 32'h8, 4'hF);
    wb_write(12'h01C, 32'h1, 4'hF);
    wb_read(12'h01C, 32'h8, "padcfg7_locked");
    // Reset asserted mid-request: no ack and no PADCFG[9] update.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE | 32'h024; wdat = 32'h4; sel = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort_ack got=%b want=0", ack);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    wb_read(12'h01C, 32'h0, "padcfg7_after_reset");
    wb_read(12'h024, 32'h0, "padcfg9_aborted");
    wb_read(12'h100, 32'h0, "gpio_out_lo_after_reset");
    vectors++;
    if (io_oeb !== '1) begin
      miscompares++;
      $display("FAIL reset_oeb got=%h want=all1", io_oeb);
    end
  endtask

  task automatic test_irq();
    @(negedge clk) io_in[33] = 1'b0;
    repeat (4) @(posedge clk);
`ifdef IO_PAD_MUX_IRQ_EN
    wb_write(12'h084, 32'h10, 4'hF);
    wb_read(12'h114, 32'h0, "irq_pend_idle");
    @(negedge clk) io_in[33] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (irq !== {2'b00, (k >= 4)}) begin
        miscompares++;
        $display("FAIL irq_timing_edge%0d got=%b want=%b", k, irq, {2'b00, (k >= 4)});
      end
    end
    wb_read(12'h114, 32'h2, "irq_pend_hi_set");
    @(negedge clk) io_in[33] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) io_in[33] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wb_write(12'h114, 32'h2, 4'hF);
    wb_read(12'h114, 32'h2, "irq_set_beats_clear");
    vectors++;
    if (irq !== 3'b001) begin
      miscompares++;
      $display("FAIL irq_still_high got=%b want=001", irq);
    end
    wb_write(12'h114, 32'h2, 4'hF);
    wb_read(12'h114, 32'h0, "irq_w1c");
    vectors++;
    if (irq !== 3'b000) begin
      miscompares++;
      $display("FAIL irq_cleared got=%b want=000", irq);
    end
`else
    wb_write(12'h084, 32'h30, 4'hF);
    wb_read(12'h084, 32'h0, "padcfg33_irqbits_absent");
    @(negedge clk) io_in[33] = 1'b1;
    repeat (4) @(posedge clk);
    wb_read(12'h114, 32'h0, "irq_pend_hi_absent");
    wb_read(12'h110, 32'h0, "irq_pend_lo_absent");
    vectors++;
    if (irq !== 3'b000) begin
      miscompares++;
      $display("FAIL irq_absent got=%b want=000", irq);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h200; sel = 4'hF;
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ack0 got=%b want=0", ack);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ack !== k[0] || rdat !== 32'h0) begin
        miscompares++;
        $display("FAIL b2b_ack%0d got ack=%b dat=%h want ack=%b dat=0", k, ack, rdat, k[0]);
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    wb_write(12'h200, 32'hFFFF_FFFF, 4'hF);
    wb_read(12'h000, 32'h0, "unmapped_write_padcfg0");
    wb_read(12'h100, 32'h0, "unmapped_write_gpio_out");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h1000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ack !== 1'b0) begin
        miscompares++;
        $display("FAIL out_of_window_ack%0d got=%b want=0", k, ack);
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_gpio_in();
    test_periph();
    test_lock();
    test_irq();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
